dram_burst_datapath: RTL and testbench

Data-path stage downstream of the DRAM timing controller. It turns the controller's per-beat write strobe, read-start pulse and command-clear signals into DQ bus traffic. On writes it holds one host line and serializes it onto the DQ bus, one beat per `wr_en` cycle. On reads it deserializes `BURST_LEN` beats from the DQ bus into one line and hands it to the host with a valid/ready handshake.

---
 rtl/dram_burst_datapath.sv | 153 +++++++++++++++
 tb/tb_dram_burst_datapath.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_datapath.sv
// dram_burst_datapath: serializes a host line onto the DQ bus and assembles
// a line from DQ read beats. Optional DQ parity is enabled with the macro
// DQ_PARITY_EN. Write beats appear one cycle after wr_en is sampled.
// The read line is held on a valid/ready handshake until the host accepts it.
module dram_burst_datapath #(
  parameter int DQ_W      = 16,
  parameter int BURST_LEN = 8
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [DQ_W*BURST_LEN-1:0] wdata,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic                      wr_en,
  output logic [DQ_W-1:0]           dq_out,
  output logic                      dq_oe,
  output logic                      dq_par_out,
  input  logic                      rd_en,
  input  logic [DQ_W-1:0]           dq_in,
  input  logic                      dq_par_in,
  input  logic                      clear,
  output logic [DQ_W*BURST_LEN-1:0] rdata,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      wr_underrun,
  output logic                      rd_drop,
  output logic                      par_err
);

  localparam int LINE_W = DQ_W * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {W_EMPTY, W_FULL, W_SEND} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_CAPT, R_HOLD} r_state_e;

  w_state_e          w_state_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  widx_q;
  logic [DQ_W-1:0]   dq_out_q;
  logic              dq_oe_q;
  logic              dq_par_q;
  logic              wr_underrun_q;

  r_state_e          r_state_q;
  logic [CNT_W-1:0]  rcnt_q;
  logic [LINE_W-1:0] rdata_q;
  logic              rd_drop_q;
  logic              par_err_q;

  logic [DQ_W-1:0]   beat_d;
  logic              beat_par_d;
  logic              rd_par_bad_d;

  assign beat_d = line_q[widx_q*DQ_W +: DQ_W];

`ifdef DQ_PARITY_EN
  assign beat_par_d   = ^beat_d;
  assign rd_par_bad_d = (^dq_in) ^ dq_par_in;
`else
  // Parity disabled: outputs stay 0 and the incoming parity bit is ignored.
  logic unused_par;
  assign unused_par   = dq_par_in;
  assign beat_par_d   = 1'b0;
  assign rd_par_bad_d = 1'b0;
`endif

  assign wready      = (w_state_q == W_EMPTY);
  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign dq_par_out  = dq_par_q;
  assign wr_underrun = wr_underrun_q;
  assign rdata       = rdata_q;
  assign rvalid      = (r_state_q == R_HOLD);
  assign rd_drop     = rd_drop_q;
  assign par_err     = par_err_q;

  // Write side: latch a line, drive one beat per wr_en, clear aborts a started burst.
  always_ff @(posedge clk) begin
    if (RST) begin
      w_state_q     <= W_EMPTY;
      line_q        <= '0;
      widx_q        <= '0;
      dq_out_q      <= '0;
      dq_oe_q       <= 1'b0;
      dq_par_q      <= 1'b0;
      wr_underrun_q <= 1'b0;
    end else begin
      dq_oe_q       <= 1'b0;
      wr_underrun_q <= 1'b0;
      case (w_state_q)
        W_EMPTY: begin
          // A strobe with nothing latched (even on the load cycle) is an underrun.
          wr_underrun_q <= wr_en;
          if (wvalid) begin
            line_q    <= wdata;
            widx_q    <= '0;
            w_state_q <= W_FULL;
          end
        end
        W_FULL, W_SEND: begin
          if (clear) begin
            // Before the first beat the line is kept; after it the rest is dropped.
            if (w_state_q == W_SEND) w_state_q <= W_EMPTY;
          end else if (wr_en) begin
            dq_out_q  <= beat_d;
            dq_par_q  <= beat_par_d;
            dq_oe_q   <= 1'b1;
            widx_q    <= widx_q + CNT_W'(1);
            w_state_q <= (widx_q == LAST_IDX) ? W_EMPTY : W_SEND;
          end
        end
        default: w_state_q <= W_EMPTY;
      endcase
    end
  end

  // Read side: capture BURST_LEN beats after rd_en, hold the line until accepted.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state_q <= R_IDLE;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rd_drop_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      rd_drop_q <= rd_en && (r_state_q != R_IDLE);
      case (r_state_q)
        R_IDLE: begin
          if (rd_en) begin
            rcnt_q    <= '0;
            r_state_q <= R_CAPT;
          end
        end
        R_CAPT: begin
          if (clear) begin
            r_state_q <= R_IDLE;
          end else begin
            rdata_q[rcnt_q*DQ_W +: DQ_W] <= dq_in;
            rcnt_q <= rcnt_q + CNT_W'(1);
            if (rd_par_bad_d) par_err_q <= 1'b1;
            if (rcnt_q == LAST_IDX) r_state_q <= R_HOLD;
          end
        end
        R_HOLD: begin
          if (rready) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_datapath.sv
// Bench for dram_burst_datapath: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the write buffer
// and read assembler.
module tb_dram_burst_datapath;
  localparam int DQ_W = 16;
  localparam int BL   = 8;
  localparam int LW   = DQ_W * BL;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic [LW-1:0] wdata = '0;
  logic          wvalid = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clear = 1'b0, rready = 1'b0;
  logic [DQ_W-1:0] dq_in = '0;
  logic          dq_par_in = 1'b0;
  logic          corrupt = 1'b0;
  logic          wready, dq_oe, dq_par_out, rvalid, wr_underrun, rd_drop, par_err;
  logic [DQ_W-1:0] dq_out;
  logic [LW-1:0] rdata;

  int errors = 0;
  int checks = 0;

  dram_burst_datapath #(.DQ_W(DQ_W), .BURST_LEN(BL)) dut (
    .clk(clk), .RST(RST), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .wr_en(wr_en), .dq_out(dq_out), .dq_oe(dq_oe), .dq_par_out(dq_par_out),
    .rd_en(rd_en), .dq_in(dq_in), .dq_par_in(dq_par_in), .clear(clear),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .wr_underrun(wr_underrun),
    .rd_drop(rd_drop), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // Model: a held line with a count of beats already sent, and a list of captured read beats.
  bit            m_full = 0;
  logic [LW-1:0] m_line = '0;
  int            m_sent = 0;
  logic [DQ_W-1:0] m_dq = '0;
  bit            m_oe = 0, m_under = 0;
  bit            m_cap = 0, m_hold = 0, m_drop = 0, m_perr = 0;
  logic [DQ_W-1:0] m_beats[$];
  logic [LW-1:0] m_rline = '0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    m_under = 0;
    m_drop  = 0;
    m_oe    = 0;
    if (RST) begin
      m_full = 0; m_sent = 0; m_dq = '0; m_cap = 0; m_hold = 0;
      m_beats.delete(); m_perr = 0;
      return;
    end
    // write buffer
    if (!m_full) begin
      m_under = wr_en;
      if (wvalid) begin m_full = 1; m_line = wdata; m_sent = 0; end
    end else if (clear) begin
      if (m_sent > 0) m_full = 0;
    end else if (wr_en) begin
      m_dq = m_line[m_sent*DQ_W +: DQ_W];
      m_oe = 1;
      m_sent++;
      if (m_sent == BL) m_full = 0;
    end
    // read assembler
    m_drop = rd_en && (m_cap || m_hold);
    if (m_hold) begin
      if (rready) m_hold = 0;
    end else if (m_cap) begin
      if (clear) begin
        m_cap = 0;
        m_beats.delete();
      end else begin
        m_beats.push_back(dq_in);
`ifdef DQ_PARITY_EN
        if ((^dq_in) != dq_par_in) m_perr = 1;
`endif
        if (m_beats.size() == BL) begin
          for (int i = 0; i < BL; i++) m_rline[i*DQ_W +: DQ_W] = m_beats[i];
          m_beats.delete();
          m_cap  = 0;
          m_hold = 1;
        end
      end
    end else if (rd_en) begin
      m_cap = 1;
    end
  endtask

  task automatic check_all();
    logic exp_par;
`ifdef DQ_PARITY_EN
    exp_par = ^m_dq;
`else
    exp_par = 1'b0;
`endif
    chk("dq_oe", dq_oe, m_oe);
    chk("dq_out", dq_out, m_dq);
    chk("dq_par_out", dq_par_out, exp_par);
    chk("wready", wready, !m_full);
    chk("wr_underrun", wr_underrun, m_under);
    chk("rvalid", rvalid, m_hold);
    if (m_hold) chk("rdata", rdata, m_rline);
    chk("rd_drop", rd_drop, m_drop);
    chk("par_err", par_err, m_perr);
  endtask

  // One clock: model consumes the current inputs, DUT samples them, outputs compared after the edge.
  task automatic cyc();
    dq_par_in = (^dq_in) ^ corrupt;
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    wvalid = 0; wr_en = 0; rd_en = 0; clear = 0; rready = 0; corrupt = 0; RST = 0;
  endtask

  initial begin
    logic [LW-1:0] ramp;
    logic [LW-1:0] exp_rd;

    // reset
    RST = 1;
    cyc(); cyc();
    chk("rst_wready", wready, 1'b1);
    chk("rst_rdata", rdata, '0);
    chk("rst_dq_out", dq_out, '0);
    idle_inputs();
    cyc();

    // write ramp line: beat i = i, with wr_en on the load cycle (underrun)
    for (int i = 0; i < BL; i++) ramp[i*DQ_W +: DQ_W] = DQ_W'(i);
    wdata = ramp; wvalid = 1; wr_en = 1;
    cyc();
    chk("load_underrun", wr_underrun, 1'b1);
    chk("load_no_oe", dq_oe, 1'b0);
    wvalid = 0;
    for (int i = 0; i < BL; i++) begin
      cyc();
      chk("ramp_beat", dq_out, LW'(i));
      chk("ramp_oe", dq_oe, 1'b1);
    end
    chk("ramp_wready_after_last", wready, 1'b1);
    wr_en = 0;
    cyc();
    chk("hold_dq_out", dq_out, LW'(BL - 1));
    // underrun with empty buffer
    wr_en = 1;
    cyc();
    chk("empty_underrun", wr_underrun, 1'b1);
    wr_en = 0;
    cyc();
    chk("underrun_one_cycle", wr_underrun, 1'b0);

    // read burst 0xA0+i, parity corrupted on beat 5
    rd_en = 1;
    cyc();
    rd_en = 0;
    for (int i = 0; i < BL; i++) begin
      dq_in = DQ_W'(16'hA0 + i);
      corrupt = (i == 5);
      cyc();
    end
    corrupt = 0;
    for (int i = 0; i < BL; i++) exp_rd[i*DQ_W +: DQ_W] = DQ_W'(16'hA0 + i);
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_line", rdata, exp_rd);
    for (int i = 0; i < 5; i++) begin
      rd_en = (i == 2);
      dq_in = DQ_W'($urandom);
      cyc();
      chk("rd_hold_stable", rdata, exp_rd);
      if (i == 2) chk("rd_drop_in_hold", rd_drop, 1'b1);
    end
    rd_en = 0; rready = 1;
    cyc();
    chk("rd_accepted", rvalid, 1'b0);
    rready = 0;

    // clean burst: par_err must persist
    rd_en = 1;
    cyc();
    rd_en = 0;
    for (int i = 0; i < BL; i++) begin dq_in = DQ_W'($urandom); cyc(); end
    rready = 1;
    cyc();
    rready = 0;

    // write clear after 3 beats (clear with wr_en: clear wins)
    wdata = {4{$urandom}}; wvalid = 1;
    cyc();
    wvalid = 0; wr_en = 1;
    cyc(); cyc(); cyc();
    clear = 1;
    cyc();
    chk("wclear_no_oe", dq_oe, 1'b0);
    chk("wclear_wready", wready, 1'b1);
    clear = 0; wr_en = 0;

    // read clear on capture cycle 4, then a fresh burst is accepted
    rd_en = 1;
    cyc();
    rd_en = 0;
    for (int i = 0; i < 3; i++) begin dq_in = DQ_W'($urandom); cyc(); end
    clear = 1;
    cyc();
    clear = 0;
    for (int i = 0; i < BL + 2; i++) begin cyc(); chk("rclear_no_rvalid", rvalid, 1'b0); end
    rd_en = 1;
    cyc();
    chk("rd_after_clear_no_drop", rd_drop, 1'b0);
    rd_en = 0;
    for (int i = 0; i < BL; i++) begin dq_in = DQ_W'($urandom); cyc(); end
    chk("rd_after_clear_rvalid", rvalid, 1'b1);
    rready = 1;
    cyc();
    rready = 0;

    // reset mid-write (beat 4) and mid-capture
    wdata = {4{$urandom}}; wvalid = 1; rd_en = 1;
    cyc();
    wvalid = 0; rd_en = 0; wr_en = 1;
    for (int i = 0; i < 4; i++) begin dq_in = DQ_W'($urandom); cyc(); end
    RST = 1;
    cyc();
    chk("rst_mid_oe", dq_oe, 1'b0);
    chk("rst_mid_dq_out", dq_out, '0);
    chk("rst_mid_wready", wready, 1'b1);
    chk("rst_mid_rvalid", rvalid, 1'b0);
    chk("rst_mid_rdata", rdata, '0);
    chk("rst_mid_par_err", par_err, 1'b0);
    idle_inputs();
    cyc();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      RST     = ($urandom_range(0, 149) == 0);
      wvalid  = ($urandom_range(0, 9) < 3);
      wdata   = {$urandom, $urandom, $urandom, $urandom};
      wr_en   = ($urandom_range(0, 1) == 1);
      clear   = ($urandom_range(0, 19) == 0);
      rd_en   = ($urandom_range(0, 4) == 0);
      rready  = ($urandom_range(0, 1) == 1);
      dq_in   = DQ_W'($urandom);
      corrupt = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
